rformat_exec_unit: RTL and testbench



---
 rtl/rformat_exec_unit.sv | 191 +++++++++++++++++++
 tb/tb_rformat_exec_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rformat_exec_unit.sv
// Multi-cycle MIPS R-format execution unit: register file, decoder and ALU
// sequenced IDLE -> READ -> EXEC -> WB, with host preload and debug readback.
module rformat_exec_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              host_wr_en,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              illegal,
    output logic              overflow,
    output logic [1:0]        dbg_state
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int MSB = DATA_W - 1;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t            r_state;
    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_illegal;
    logic              r_overflow;
    logic              r_done;
    logic [DATA_W-1:0] r_dbg;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [4:0]        w_shamt;
    logic [ADDR_W-1:0] w_rs;
    logic [ADDR_W-1:0] w_rt;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_big_shift;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_ill;
    logic              w_alu_ovf;
    logic              w_ready;

    // Handshake: a transfer happens on a rising edge where instr_valid and
    // instr_ready are both high; the sequencer holds instr stable until then.
    assign w_ready     = reset && (r_state == S_IDLE) && !host_wr_en;
    assign instr_ready = w_ready;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign result      = r_result;
    assign illegal     = r_illegal;
    assign overflow    = r_overflow;
    assign dbg_data    = r_dbg;
    assign dbg_state   = r_state;

    assign w_op    = r_instr[31:26];
    assign w_rs    = r_instr[21 +: ADDR_W];
    assign w_rt    = r_instr[16 +: ADDR_W];
    assign w_rd    = r_instr[11 +: ADDR_W];
    assign w_shamt = r_instr[10:6];
    assign w_funct = r_instr[5:0];

    assign w_rd_a = (w_rs == '0) ? '0 : r_regs[w_rs];
    assign w_rd_b = (w_rt == '0) ? '0 : r_regs[w_rt];

    assign w_sum       = r_a + r_b;
    assign w_diff      = r_a - r_b;
    assign w_big_shift = (32'(w_shamt) >= DATA_W);

    always_comb begin
        w_alu_res = '0;
        w_alu_ill = 1'b0;
        w_alu_ovf = 1'b0;
        if (w_op != 6'd0) begin
            w_alu_ill = 1'b1;
        end else begin
            case (w_funct)
                F_ADD: begin
                    w_alu_res = w_sum;
                    w_alu_ovf = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
                end
                F_SUB: begin
                    w_alu_res = w_diff;
                    w_alu_ovf = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
                end
                F_AND:  w_alu_res = r_a & r_b;
                F_OR:   w_alu_res = r_a | r_b;
                F_XOR:  w_alu_res = r_a ^ r_b;
                F_NOR:  w_alu_res = ~(r_a | r_b);
                F_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                F_SLTU: w_alu_res = {{(DATA_W-1){1'b0}}, (r_a < r_b)};
                F_SLL:  w_alu_res = w_big_shift ? '0 : (r_b << w_shamt);
                F_SRL:  w_alu_res = w_big_shift ? '0 : (r_b >> w_shamt);
                F_SRA:  w_alu_res = w_big_shift ? {DATA_W{r_b[MSB]}}
                                                : $unsigned($signed(r_b) >>> w_shamt);
                default: w_alu_ill = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_instr    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_illegal  <= 1'b0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid && w_ready) begin
                        r_instr <= instr;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_a     <= w_rd_a;
                    r_b     <= w_rd_b;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result   <= w_alu_res;
                    r_illegal  <= w_alu_ill;
                    r_overflow <= w_alu_ovf;
                    r_done     <= 1'b1;
                    r_state    <= S_WB;
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_IDLE) begin
            if (host_wr_en && (host_wr_addr != '0)) begin
                r_regs[host_wr_addr] <= host_wr_data;
            end
        end else if (r_state == S_WB) begin
            if (!r_illegal && (w_rd != '0)) begin
                r_regs[w_rd] <= r_result;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dbg <= '0;
        end else begin
            r_dbg <= (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
        end
    end
endmodule

// File: tb/tb_rformat_exec_unit.sv
// Self-checking bench for rformat_exec_unit: directed scenarios plus random
// instruction streams checked against an arithmetic reference model.
module tb_rformat_exec_unit;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_JR   = 6'b001000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic        host_wr_en = 1'b0;
    logic [4:0]  host_wr_addr = '0;
    logic [31:0] host_wr_data = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        illegal;
    logic        overflow;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] mregs [32];
    logic [5:0]  funct_tab [12];

    rformat_exec_unit #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy(busy), .done(done), .result(result),
        .illegal(illegal), .overflow(overflow), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    // Reference semantics from the instruction-set rules, on 32-bit words.
    function automatic void model_exec(input logic [31:0] ins, output logic [31:0] res,
                                       output logic ill, output logic ovf);
        logic [31:0] a, b;
        longint s;
        int sh;
        a = mregs[ins[25:21]];
        b = mregs[ins[20:16]];
        sh = int'(ins[10:6]);
        res = '0; ill = 1'b0; ovf = 1'b0;
        if (ins[31:26] != 6'd0) ill = 1'b1;
        else case (ins[5:0])
            F_ADD: begin
                s = longint'($signed(a)) + longint'($signed(b));
                res = s[31:0];
                ovf = (s != longint'($signed(res)));
            end
            F_SUB: begin
                s = longint'($signed(a)) - longint'($signed(b));
                res = s[31:0];
                ovf = (s != longint'($signed(res)));
            end
            F_AND:  res = a & b;
            F_OR:   res = a | b;
            F_XOR:  res = a ^ b;
            F_NOR:  res = ~(a | b);
            F_SLT:  res = (int'($signed(a)) < int'($signed(b))) ? 32'd1 : 32'd0;
            F_SLTU: res = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            F_SLL:  res = (sh >= 32) ? 32'd0 : b << sh;
            F_SRL:  res = (sh >= 32) ? 32'd0 : b >> sh;
            F_SRA:  res = (sh >= 32) ? {32{b[31]}} : 32'(int'($signed(b)) >>> sh);
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic host_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clock);
        host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
        @(negedge clock);
        host_wr_en = 1'b0;
        if (a != 5'd0) mregs[a] = d;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] a);
        @(negedge clock);
        dbg_addr = a;
        @(negedge clock);
        check(tag, dbg_data, mregs[a]);
    endtask

    // Drives one instruction and checks latency, outputs and write-back.
    // poke issues a host write to R7 while the unit is busy; it must be dropped.
    task automatic run_instr(input logic [31:0] ins, input bit poke);
        logic [31:0] er;
        logic ei, eo;
        int cnt;
        model_exec(ins, er, ei, eo);
        @(negedge clock);
        instr_valid = 1'b1; instr = ins;
        #1;
        cnt = 0;
        while (!instr_ready && cnt < 20) begin
            @(negedge clock); #1; cnt++;
        end
        if (!instr_ready) begin
            check("ready_timeout", 0, 1);
            instr_valid = 1'b0;
            return;
        end
        @(negedge clock);
        instr_valid = 1'b0;
        if (poke) begin
            host_wr_en = 1'b1; host_wr_addr = 5'd7; host_wr_data = ~mregs[7];
        end
        cnt = 1;
        while (!done && cnt < 10) begin
            @(negedge clock);
            host_wr_en = 1'b0;
            cnt++;
        end
        check("done_latency", cnt, 3);
        check("result", result, er);
        check("illegal", illegal, ei);
        check("overflow", overflow, eo);
        if (!ei && ins[15:11] != 5'd0) mregs[ins[15:11]] = er;
        @(negedge clock);
        check("done_pulse", done, 0);
        check("ready_back", instr_ready, 1);
        dbg_addr = ins[15:11];
        @(negedge clock);
        check("wb_reg", dbg_data, mregs[ins[15:11]]);
    endtask

    initial begin
        int cnt;
        logic [31:0] old;
        funct_tab = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR,
                      F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_JR};
        for (int i = 0; i < 32; i++) mregs[i] = '0;

        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_illegal", illegal, 0);
        check("rst_overflow", overflow, 0);
        check("rst_dbg", dbg_data, 0);
        check("rst_ready", instr_ready, 0);
        reset = 1'b1;

        host_write(5'd1, 32'd212);
        host_write(5'd2, 32'd32);
        run_instr(32'h0022_1820, 1'b0);
        check("plan_add", result, 244);
        run_instr(enc(0, 1, 2, 3, 0, F_SUB), 1'b0);
        check("plan_sub", result, 180);
        run_instr(enc(0, 1, 2, 3, 0, F_AND), 1'b0);
        check("plan_and", result, 0);
        run_instr(enc(0, 1, 2, 3, 0, F_OR), 1'b0);
        check("plan_or", result, 244);
        run_instr(enc(0, 2, 1, 3, 0, F_SLT), 1'b0);
        check("plan_slt", result, 1);
        host_write(5'd2, 32'hFFFF_FFFF);
        host_write(5'd1, 32'd1);
        run_instr(enc(0, 2, 1, 3, 0, F_SLTU), 1'b0);
        check("plan_sltu", result, 0);

        host_write(5'd1, 32'h7FFF_FFFF);
        host_write(5'd2, 32'd1);
        run_instr(enc(0, 1, 2, 3, 0, F_ADD), 1'b0);
        check("plan_ovf_res", result, 32'h8000_0000);
        check("plan_ovf_flag", overflow, 1);
        run_instr(enc(0, 0, 3, 4, 31, F_SRA), 1'b0);
        check("plan_sra", result, 32'hFFFF_FFFF);

        run_instr(enc(1, 1, 2, 3, 0, F_ADD), 1'b0);
        check("plan_ill_op", illegal, 1);
        run_instr(enc(0, 1, 2, 3, 0, F_JR), 1'b0);
        check("plan_ill_fn", illegal, 1);
        check_reg("plan_ill_r3", 5'd3);
        run_instr(enc(0, 1, 2, 0, 0, F_ADD), 1'b0);
        check_reg("plan_r0_wb", 5'd0);
        host_write(5'd0, 32'h1234_5678);
        check_reg("plan_r0_host", 5'd0);

        // Busy host write to R7 must be ignored
        host_write(5'd7, 32'h0000_00A5);
        run_instr(enc(0, 1, 2, 8, 0, F_OR), 1'b1);
        check_reg("busy_host_r7", 5'd7);

        // Continuous valid with rd = 0: one acceptance every four cycles
        @(negedge clock);
        instr_valid = 1'b1; instr = enc(0, 1, 2, 0, 0, F_ADD);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (instr_ready) cnt++;
            @(negedge clock);
        end
        instr_valid = 1'b0;
        check("ready_1_in_4", cnt, 4);

        // Host write and instruction together: host first, then accept
        @(negedge clock);
        host_wr_en = 1'b1; host_wr_addr = 5'd5; host_wr_data = 32'h0BAD_F00D;
        instr_valid = 1'b1; instr = enc(0, 5, 0, 6, 0, F_ADD);
        #1;
        check("contend_ready0", instr_ready, 0);
        @(negedge clock);
        host_wr_en = 1'b0;
        mregs[5] = 32'h0BAD_F00D;
        #1;
        check("contend_ready1", instr_ready, 1);
        @(negedge clock);
        instr_valid = 1'b0;
        cnt = 1;
        while (!done && cnt < 10) begin @(negedge clock); cnt++; end
        check("contend_latency", cnt, 3);
        check("contend_result", result, 32'h0BAD_F00D);
        mregs[6] = 32'h0BAD_F00D;
        check_reg("contend_r6", 5'd6);

        // Debug read shows the value from before a write on the same edge
        host_write(5'd9, 32'h1111_1111);
        @(negedge clock);
        old = mregs[9];
        dbg_addr = 5'd9;
        host_wr_en = 1'b1; host_wr_addr = 5'd9; host_wr_data = 32'h2222_2222;
        @(negedge clock);
        host_wr_en = 1'b0;
        check("dbg_old", dbg_data, old);
        mregs[9] = 32'h2222_2222;
        @(negedge clock);
        check("dbg_new", dbg_data, mregs[9]);

        // Random regression
        for (int i = 1; i < 32; i++) host_write(5'(i), $urandom);
        for (int k = 0; k < 60; k++) begin
            logic [5:0] op;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: host_write(5'($urandom_range(0, 31)), 32'h7FFF_FFFF);
                    1: host_write(5'($urandom_range(0, 31)), 32'h8000_0000);
                    default: host_write(5'($urandom_range(0, 31)), $urandom);
                endcase
            end
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            run_instr(enc(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          funct_tab[$urandom_range(0, 11)]), ($urandom_range(0, 4) == 0));
        end
        check_reg("rand_r7", 5'd7);

        // Reset during EXEC drops the write and clears everything
        host_write(5'd1, 32'd5);
        host_write(5'd2, 32'd9);
        host_write(5'd3, 32'd7);
        @(negedge clock);
        instr_valid = 1'b1; instr = enc(0, 1, 2, 3, 0, F_ADD);
        #1;
        check("mid_ready", instr_ready, 1);
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        check("mid_in_exec", dbg_state, 2);
        reset = 1'b0;
        @(negedge clock);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_result", result, 0);
        check("mid_illegal", illegal, 0);
        check("mid_overflow", overflow, 0);
        check("mid_dbg", dbg_data, 0);
        check("mid_ready_low", instr_ready, 0);
        reset = 1'b1;
        #1;
        check("mid_ready_after", instr_ready, 1);
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        check_reg("mid_r3", 5'd3);
        check_reg("mid_r1", 5'd1);
        check_reg("mid_r2", 5'd2);
        check("mid_result_hold", result, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
